// File: rtl/clk_div_multi.sv
// clk_div_multi: N-channel programmable clock / strobe divider.
// Period/high updates wait in a shadow and take effect at a channel wrap.
module clk_div_multi #(
   parameter int CLK_FREQ   = 16_000_000,
   parameter int CHANNELS   = 4,
   parameter int CNT_W      = 32,
   parameter int DEFAULT_HZ = 1,
   localparam int CHAN_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] enable,
   input  logic                sync,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CHAN_W-1:0]   cfg_chan,
   input  logic [CNT_W-1:0]    cfg_period,
   input  logic [CNT_W-1:0]    cfg_high,
   output logic                cfg_err,
   output logic [CHANNELS-1:0] div_clk,
   output logic [CHANNELS-1:0] div_pulse
);

   localparam logic [CNT_W-1:0] RST_PERIOD =
      CNT_W'(CLK_FREQ / DEFAULT_HZ);
   localparam logic [CNT_W-1:0] RST_HIGH = RST_PERIOD >> 1;
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   typedef enum logic {RUN, PEND} ch_st_e;

   ch_st_e           st_q      [CHANNELS];
   ch_st_e           st_d      [CHANNELS];
   logic [CNT_W-1:0] period_q  [CHANNELS];
   logic [CNT_W-1:0] period_d  [CHANNELS];
   logic [CNT_W-1:0] high_q    [CHANNELS];
   logic [CNT_W-1:0] high_d    [CHANNELS];
   logic [CNT_W-1:0] cnt_q     [CHANNELS];
   logic [CNT_W-1:0] cnt_d     [CHANNELS];
   logic [CNT_W-1:0] sh_per_q  [CHANNELS];
   logic [CNT_W-1:0] sh_per_d  [CHANNELS];
   logic [CNT_W-1:0] sh_high_q [CHANNELS];
   logic [CNT_W-1:0] sh_high_d [CHANNELS];

   logic [CHANNELS-1:0] div_clk_q, div_clk_d;
   logic [CHANNELS-1:0] div_pulse_q, div_pulse_d;
   logic                cfg_err_q, cfg_err_d;
   logic                chan_ok, cfg_ok, cfg_fire, cfg_take;

   // Handshake: a channel with a shadow still waiting refuses new writes.
   always_comb begin
      chan_ok   = int'(cfg_chan) < CHANNELS;
      cfg_ready = 1'b1;
      for (int i = 0; i < CHANNELS; i++) begin
         if (cfg_chan == CHAN_W'(i) && st_q[i] == PEND) begin
            cfg_ready = 1'b0;
         end
      end
      cfg_ok = chan_ok && (cfg_period >= CNT_W'(2)) &&
               (cfg_high != '0) && (cfg_high < cfg_period);
      cfg_fire  = cfg_valid && cfg_ready;
      cfg_take  = cfg_fire && cfg_ok;
      cfg_err_d = cfg_fire && !cfg_ok;
   end

   // Per-channel next state: sync, then enabled count, then disabled hold.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         st_d[i]        = st_q[i];
         period_d[i]    = period_q[i];
         high_d[i]      = high_q[i];
         cnt_d[i]       = cnt_q[i];
         sh_per_d[i]    = sh_per_q[i];
         sh_high_d[i]   = sh_high_q[i];
         div_clk_d[i]   = div_clk_q[i];
         div_pulse_d[i] = 1'b0;
         if (sync) begin
            if (st_q[i] == PEND) begin
               period_d[i] = sh_per_q[i];
               high_d[i]   = sh_high_q[i];
               st_d[i]     = RUN;
            end
            cnt_d[i]     = period_d[i] - ONE;
            div_clk_d[i] = 1'b0;
         end else if (enable[i]) begin
            if (cnt_q[i] == period_q[i] - ONE) begin
               cnt_d[i] = '0;
               if (st_q[i] == PEND) begin
                  period_d[i] = sh_per_q[i];
                  high_d[i]   = sh_high_q[i];
                  st_d[i]     = RUN;
               end
            end else begin
               cnt_d[i] = cnt_q[i] + ONE;
            end
            div_clk_d[i]   = cnt_d[i] < high_d[i];
            div_pulse_d[i] = cnt_d[i] == '0;
         end else if (st_q[i] == PEND) begin
            period_d[i] = sh_per_q[i];
            high_d[i]   = sh_high_q[i];
            st_d[i]     = RUN;
            cnt_d[i]    = sh_per_q[i] - ONE;
         end
         if (cfg_take && cfg_chan == CHAN_W'(i)) begin
            st_d[i]      = PEND;
            sh_per_d[i]  = cfg_period;
            sh_high_d[i] = cfg_high;
         end
      end
   end

   // State registers; reset lands every channel at its default rate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            st_q[i]      <= RUN;
            period_q[i]  <= RST_PERIOD;
            high_q[i]    <= RST_HIGH;
            cnt_q[i]     <= RST_PERIOD - ONE;
            sh_per_q[i]  <= '0;
            sh_high_q[i] <= '0;
         end
         div_clk_q   <= '0;
         div_pulse_q <= '0;
         cfg_err_q   <= 1'b0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            st_q[i]      <= st_d[i];
            period_q[i]  <= period_d[i];
            high_q[i]    <= high_d[i];
            cnt_q[i]     <= cnt_d[i];
            sh_per_q[i]  <= sh_per_d[i];
            sh_high_q[i] <= sh_high_d[i];
         end
         div_clk_q   <= div_clk_d;
         div_pulse_q <= div_pulse_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign div_clk   = div_clk_q;
   assign div_pulse = div_pulse_q;
   assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed scenarios plus random traffic,
// checked cycle by cycle against an integer reference model.
module tb_clk_div_multi;

   localparam int NCH = 3;
   localparam int CW  = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [NCH-1:0] en;
   logic           sync;
   logic           cv;
   logic           cfg_ready;
   logic [CW-1:0]  cc;
   logic [7:0]     cp;
   logic [7:0]     ch;
   logic           cfg_err;
   logic [NCH-1:0] div_clk;
   logic [NCH-1:0] div_pulse;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state, plain integers
   int m_per [NCH];
   int m_high[NCH];
   int m_ph  [NCH];
   int m_sp  [NCH];
   int m_sh  [NCH];
   bit m_pend[NCH];
   bit m_clk [NCH];
   bit m_pul [NCH];
   bit m_err;

   clk_div_multi #(
      .CLK_FREQ  (16),
      .CHANNELS  (NCH),
      .CNT_W     (8),
      .DEFAULT_HZ(4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (en),
      .sync      (sync),
      .cfg_valid (cv),
      .cfg_ready (cfg_ready),
      .cfg_chan  (cc),
      .cfg_period(cp),
      .cfg_high  (ch),
      .cfg_err   (cfg_err),
      .div_clk   (div_clk),
      .div_pulse (div_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_per[i]  = 4;
         m_high[i] = 2;
         m_ph[i]   = 3;
         m_sp[i]   = 0;
         m_sh[i]   = 0;
         m_pend[i] = 1'b0;
         m_clk[i]  = 1'b0;
         m_pul[i]  = 1'b0;
      end
      m_err = 1'b0;
   endtask

   task automatic model_apply(input int i);
      m_per[i]  = m_sp[i];
      m_high[i] = m_sh[i];
      m_pend[i] = 1'b0;
   endtask

   function automatic bit model_ready();
      int c = int'(cc);
      if (c >= NCH) return 1'b1;
      return !m_pend[c];
   endfunction

   // one clock edge of the spec's rules, on pre-edge inputs
   task automatic model_edge();
      int  c;
      bit  fire, ok;
      int  nxt;
      c    = int'(cc);
      fire = cv && model_ready();
      ok   = c < NCH && cp >= 2 && ch >= 1 && ch < cp;
      for (int i = 0; i < NCH; i++) begin
         if (sync) begin
            if (m_pend[i]) model_apply(i);
            m_ph[i]  = m_per[i] - 1;
            m_clk[i] = 1'b0;
            m_pul[i] = 1'b0;
         end else if (en[i]) begin
            nxt = (m_ph[i] + 1) % m_per[i];
            if (nxt == 0 && m_pend[i]) model_apply(i);
            m_ph[i]  = nxt;
            m_clk[i] = nxt < m_high[i];
            m_pul[i] = nxt == 0;
         end else begin
            m_pul[i] = 1'b0;
            if (m_pend[i]) begin
               model_apply(i);
               m_ph[i] = m_per[i] - 1;
            end
         end
         if (fire && ok && c == i) begin
            m_pend[i] = 1'b1;
            m_sp[i]   = int'(cp);
            m_sh[i]   = int'(ch);
         end
      end
      m_err = fire && !ok;
   endtask

   task automatic step();
      #1;
      check("cfg_ready", 32'(cfg_ready), 32'(model_ready()));
      @(posedge clk);
      model_edge();
      #1;
      for (int i = 0; i < NCH; i++) begin
         check($sformatf("div_clk%0d", i),
               32'(div_clk[i]), 32'(m_clk[i]));
         check($sformatf("div_pulse%0d", i),
               32'(div_pulse[i]), 32'(m_pul[i]));
      end
      check("cfg_err", 32'(cfg_err), 32'(m_err));
   endtask

   task automatic cyc(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic cfg(input int c, input int p, input int h);
      cv = 1'b1;
      cc = CW'(c);
      cp = 8'(p);
      ch = 8'(h);
      step();
      cv = 1'b0;
   endtask

   task automatic default_pattern(input string tag);
      for (int k = 0; k < 8; k++) begin
         step();
         check({tag, "_clk"}, 32'(div_clk[0]), 32'((k % 4) < 2));
         check({tag, "_pul"}, 32'(div_pulse[0]), 32'(k % 4 == 0));
         check({tag, "_ch1"}, 32'({div_clk[1], div_pulse[1]}), 0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      en    = '0;
      sync  = 1'b0;
      cv    = 1'b0;
      cc    = '0;
      cp    = '0;
      ch    = '0;
      model_reset();
      #1;
      check("rst_clk", 32'(div_clk), 0);
      check("rst_pulse", 32'(div_pulse), 0);
      check("rst_err", 32'(cfg_err), 0);
      check("rst_ready", 32'(cfg_ready), 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // default 4-cycle rate on ch0, ch1 idle
      en = 3'b001;
      default_pattern("s1");

      // reprogram mid-period; a second write waits while pending
      step();
      cfg(0, 5, 1);
      check("s2_ready_pend", 32'(cfg_ready), 0);
      cyc(2);
      cv = 1'b1;
      cc = 2'd0;
      cp = 8'd7;
      ch = 8'd2;
      cyc(3);
      cv = 1'b0;
      cyc(20);

      // rejected writes leave outputs alone
      cfg(0, 1, 0);
      check("s3_err_per", 32'(cfg_err), 1);
      cyc(1);
      check("s3_err_clear", 32'(cfg_err), 0);
      cfg(0, 5, 0);
      cfg(0, 5, 5);
      cfg(3, 5, 1);
      check("s3_err_chan", 32'(cfg_err), 1);
      cyc(12);

      // both channels, then a common sync
      cfg(0, 5, 1);
      cyc(8);
      en = 3'b011;
      cfg(1, 3, 1);
      cyc(9);
      sync = 1'b1;
      step();
      check("s4_sync_clk", 32'(div_clk[1:0]), 0);
      sync = 1'b0;
      step();
      check("s4_pulse_both", 32'(div_pulse[1:0]), 3);

      // disable ch0 in its high phase, reprogram while disabled
      en = 3'b010;
      cfg(0, 6, 3);
      cyc(3);
      check("s5_hold_clk", 32'(div_clk[0]), 1);
      check("s5_no_pulse", 32'(div_pulse[0]), 0);
      en = 3'b011;
      step();
      check("s5_reenable", 32'(div_pulse[0]), 1);
      cyc(12);

      // widest period on ch2
      en = 3'b111;
      cfg(2, 255, 200);
      cyc(530);

      // asynchronous reset in the middle of a count
      #2;
      rst_n = 1'b0;
      #1;
      check("s6_async_clk", 32'(div_clk), 0);
      check("s6_async_pulse", 32'(div_pulse), 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      en = 3'b001;
      rst_n = 1'b1;
      default_pattern("s6");

      // random traffic
      for (int k = 0; k < 2500; k++) begin
         if ($urandom_range(0, 9) < 8) en = '1;
         else en = NCH'($urandom_range(0, 7));
         sync = ($urandom_range(0, 49) == 0);
         cv   = ($urandom_range(0, 4) == 0);
         cc   = CW'($urandom_range(0, 3));
         cp   = 8'($urandom_range(0, 9));
         ch   = 8'($urandom_range(0, 9));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
